// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx : 8N1 UART transmitter with a small write FIFO.
//
// Bytes pushed with a single-cycle write strobe are queued in a
// 2**FIFO_AW-entry FIFO and serialised LSB-first onto tx. Frames go out
// back-to-back until the FIFO is empty. The bit period is clkdiv+1 clk
// cycles, with clkdiv re-sampled at the start of every bit. This is the
// same timing convention the team's UART receiver uses.
//
// Optional build macro: UART_TX_PARITY_EN
//   When it is defined, an even-parity bit (the XOR of the 8 data bits) is
//   sent between data bit 7 and the stop bit. This adds a PARITY state.
//   When it is undefined, the transmitter is plain 8N1.
//
// Ports:
//   clk     in   system clock
//   rst     in   synchronous reset, active-high
//   clkdiv  in   [31:0] bit period minus one, in clk cycles
//   wr      in   write strobe; pushes data when the FIFO is not full
//   data    in   [7:0] byte to transmit
//   full    out  FIFO holds 2**FIFO_AW entries
//   empty   out  FIFO holds 0 entries
//   count   out  [FIFO_AW:0] FIFO occupancy (registered)
//   ovf     out  one-cycle pulse: a write was dropped because FIFO was full
//   busy    out  frame in progress or FIFO non-empty
//   tx      out  serial line, idle high (registered)
// ---------------------------------------------------------------------------
module uart_tx #(
    parameter int FIFO_AW = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        clkdiv,
    input  logic               wr,
    input  logic [7:0]         data,
    output logic               full,
    output logic               empty,
    output logic [FIFO_AW:0]   count,
    output logic               ovf,
    output logic               busy,
    output logic               tx
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd4;

    // Even parity: the line bit that makes the total count of ones even.
    function automatic logic even_parity(input logic [7:0] b);
        return ^b;
    endfunction
`endif

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wptr_r;
    logic [FIFO_AW-1:0] rptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               ovf_r;
    logic [2:0]         state_r;
    logic [31:0]        timer_r;
    logic [2:0]         bitcnt_r;
    logic [7:0]         shift_r;
    logic               tx_r;
`ifdef UART_TX_PARITY_EN
    logic               par_r;
`endif

    logic               push_s;
    logic               pop_s;
    logic               expire_s;
    logic [7:0]         head_s;

    assign full     = (count_r == FULL_CNT);
    assign empty    = (count_r == {(FIFO_AW+1){1'b0}});
    assign busy     = (state_r != S_IDLE) | ~empty;
    assign count    = count_r;
    assign ovf      = ovf_r;
    assign tx       = tx_r;

    assign push_s   = wr & ~full;
    assign expire_s = (timer_r == 32'd0);
    assign head_s   = mem_r[rptr_r];

    // Pop the head when idle, or at the end of a stop bit so that frames run back-to-back.
    always_comb begin
        pop_s = 1'b0;
        if (empty) begin
            pop_s = 1'b0;
        end else if (state_r == S_IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == S_STOP) && expire_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wptr_r] <= data;
        end
    end

    // FIFO pointers, occupancy and the overflow pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {FIFO_AW{1'b0}};
            rptr_r  <= {FIFO_AW{1'b0}};
            count_r <= {(FIFO_AW+1){1'b0}};
            ovf_r   <= 1'b0;
        end else begin
            // full is the pre-edge state, so a same-cycle pop cannot rescue the write
            ovf_r <= wr & full;
            if (push_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

    // Transmit FSM. Each bit is held for clkdiv+1 cycles; the timer reloads at every bit start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= S_IDLE;
            tx_r     <= 1'b1;
            timer_r  <= 32'd0;
            bitcnt_r <= 3'd0;
            shift_r  <= 8'd0;
`ifdef UART_TX_PARITY_EN
            par_r    <= 1'b0;
`endif
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (pop_s) begin
                        shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                        par_r    <= even_parity(head_s);
`endif
                        tx_r     <= 1'b0;
                        bitcnt_r <= 3'd0;
                        timer_r  <= clkdiv;
                        state_r  <= S_START;
                    end
                end
                S_START: begin
                    if (expire_s) begin
                        tx_r    <= shift_r[0];
                        timer_r <= clkdiv;
                        state_r <= S_DATA;
                    end else begin
                        timer_r <= timer_r - 32'd1;
                    end
                end
                S_DATA: begin
                    if (expire_s) begin
                        timer_r <= clkdiv;
                        if (bitcnt_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= par_r;
                            state_r <= S_PARITY;
`else
                            tx_r    <= 1'b1;
                            state_r <= S_STOP;
`endif
                        end else begin
                            shift_r  <= {1'b0, shift_r[7:1]};
                            tx_r     <= shift_r[1];
                            bitcnt_r <= bitcnt_r + 3'd1;
                        end
                    end else begin
                        timer_r <= timer_r - 32'd1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (expire_s) begin
                        tx_r    <= 1'b1;
                        timer_r <= clkdiv;
                        state_r <= S_STOP;
                    end else begin
                        timer_r <= timer_r - 32'd1;
                    end
                end
`endif
                S_STOP: begin
                    if (expire_s) begin
                        if (pop_s) begin
                            // next frame starts immediately, no idle gap
                            shift_r  <= head_s;
`ifdef UART_TX_PARITY_EN
                            par_r    <= even_parity(head_s);
`endif
                            tx_r     <= 1'b0;
                            bitcnt_r <= 3'd0;
                            timer_r  <= clkdiv;
                            state_r  <= S_START;
                        end else begin
                            state_r  <= S_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r - 32'd1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule
